flit_rx_reassembler: RTL and testbench



---
 rtl/flit_rx_reassembler.sv | 216 +++++++++++++++++++++
 tb/tb_flit_rx_reassembler.sv | 617 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_rx_reassembler.sv
// flit_rx_reassembler: NoC egress endpoint that buffers credited router
// flits in a small FIFO and reassembles them into AXI-Stream beats.
//
// Ports:
//   clk, rst        - single clock, synchronous active-high reset
//   data_in         - flit payload (TDATA_WIDTH/SERIALIZATION_FACTOR bits)
//   dest_in         - flit destination ({tid, tdest})
//   is_tail_in      - last flit of the packet
//   send_in         - flit valid this cycle
//   credit_out      - one-cycle pulse per FIFO slot freed
//   axis_tvalid/tready/tdata/tlast/tdest - AXI-Stream master
//   overflow        - sticky: flit arrived while the FIFO was full
//
// Optional build macro FLIT_RX_STATS_EN adds:
//   beat_count      - 32-bit count of AXIS handshakes
//   pkt_count       - 32-bit count of handshakes with tlast=1

module flit_rx_reassembler #(
    parameter int TDATA_WIDTH          = 512,
    parameter int DEST_WIDTH           = 6,
    parameter int SERIALIZATION_FACTOR = 4,
    parameter int FLIT_BUFFER_DEPTH    = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]                        dest_in,
    input  logic                                         is_tail_in,
    input  logic                                         send_in,
    output logic                                         credit_out,
    output logic                                         axis_tvalid,
    input  logic                                         axis_tready,
    output logic [TDATA_WIDTH-1:0]                       axis_tdata,
    output logic                                         axis_tlast,
    output logic [DEST_WIDTH-1:0]                        axis_tdest,
    output logic                                         overflow
`ifdef FLIT_RX_STATS_EN
    ,
    output logic [31:0]                                  beat_count,
    output logic [31:0]                                  pkt_count
`endif
);

    localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int PTR_W      = $clog2(FLIT_BUFFER_DEPTH);
    localparam int CNT_W      = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int IDX_W      = (SERIALIZATION_FACTOR > 1) ?
                                $clog2(SERIALIZATION_FACTOR) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FLIT_BUFFER_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FLIT_BUFFER_DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SERIALIZATION_FACTOR - 1);

    typedef enum logic {
        COLLECT,
        PRESENT
    } state_t;

    // Flit storage. Contents are don't-care while the slot is free, so
    // the array carries no reset.
    logic [FLIT_WIDTH-1:0] mem_data [FLIT_BUFFER_DEPTH];
    logic [DEST_WIDTH-1:0] mem_dest [FLIT_BUFFER_DEPTH];
    logic                  mem_tail [FLIT_BUFFER_DEPTH];

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [DEST_WIDTH-1:0]  tdest_q, tdest_d;
    logic                   tlast_q, tlast_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   credit_q, credit_d;
    logic                   overflow_q, overflow_d;

    logic                   full;
    logic                   empty;
    logic                   handshake;
    logic                   wr_en;
    logic                   rd_en;
    logic [FLIT_WIDTH-1:0]  head_data;
    logic [DEST_WIDTH-1:0]  head_dest;
    logic                   head_tail;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Full/empty are judged on the count at the start of the cycle, so a
    // flit arriving while full is dropped even if a slot frees this cycle.
    always_comb begin
        full      = (count_q == DEPTH_C);
        empty     = (count_q == '0);
        handshake = (state_q == PRESENT) && axis_tready;
        wr_en     = send_in && !full;
        rd_en     = !empty && ((state_q == COLLECT) || handshake);
        head_data = mem_data[rd_ptr_q];
        head_dest = mem_dest[rd_ptr_q];
        head_tail = mem_tail[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d   = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        credit_d   = rd_en;
        overflow_d = overflow_q || (send_in && full);
    end

    // Assembly FSM. The beat register doubles as the assembly buffer; it
    // is cleared when slot 0 is loaded so short beats are zero-padded.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tdata_d = tdata_q;
        tdest_d = tdest_q;
        tlast_d = tlast_q;

        if (handshake) begin
            state_d = COLLECT;
            tlast_d = 1'b0;
        end

        // A handshake dequeues in the same cycle (idx is 0 there).
        if (rd_en) begin
            if (idx_q == '0) begin
                tdata_d = '0;
                tdest_d = head_dest;
            end
            tdata_d[idx_q*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
            if ((idx_q == IDX_LAST) || head_tail) begin
                state_d = PRESENT;
                idx_d   = '0;
                tlast_d = head_tail;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            idx_q      <= '0;
            tdata_q    <= '0;
            tdest_q    <= '0;
            tlast_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tdata_q    <= tdata_d;
            tdest_q    <= tdest_d;
            tlast_q    <= tlast_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr_q] <= data_in;
            mem_dest[wr_ptr_q] <= dest_in;
            mem_tail[wr_ptr_q] <= is_tail_in;
        end
    end

    assign credit_out  = credit_q;
    assign axis_tvalid = (state_q == PRESENT);
    assign axis_tdata  = tdata_q;
    assign axis_tlast  = tlast_q;
    assign axis_tdest  = tdest_q;
    assign overflow    = overflow_q;

`ifdef FLIT_RX_STATS_EN
    logic [31:0] beat_count_q, beat_count_d;
    logic [31:0] pkt_count_q, pkt_count_d;

    always_comb begin
        beat_count_d = beat_count_q;
        pkt_count_d  = pkt_count_q;
        if (handshake) begin
            beat_count_d = beat_count_q + 32'd1;
            if (tlast_q) begin
                pkt_count_d = pkt_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            beat_count_q <= beat_count_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign beat_count = beat_count_q;
    assign pkt_count  = pkt_count_q;
`endif

endmodule

// File: tb/tb_flit_rx_reassembler.sv
// tb_flit_rx_reassembler: directed and randomized checks of the flit
// reassembler against a packet-level reference model.

`timescale 1ns/1ps

module tb_flit_rx_reassembler;

    localparam int TW    = 512;
    localparam int DW    = 6;
    localparam int SF    = 4;
    localparam int DEPTH = 4;
    localparam int FW    = TW / SF;

    typedef struct {
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          tail;
    } flit_t;

    typedef struct {
        logic [TW-1:0] data;
        logic [DW-1:0] dest;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] data_in;
    logic [DW-1:0] dest_in;
    logic          is_tail_in;
    logic          send_in;
    logic          credit_out;
    logic          axis_tvalid;
    logic          axis_tready;
    logic [TW-1:0] axis_tdata;
    logic          axis_tlast;
    logic [DW-1:0] axis_tdest;
    logic          overflow;
`ifdef FLIT_RX_STATS_EN
    logic [31:0]   beat_count;
    logic [31:0]   pkt_count;
`endif

    flit_t tx_q[$];
    beat_t exp_q[$];
    beat_t obs[$];

    int    total      = 0;
    int    bad        = 0;
    int    credit_cnt = 0;
    int    tb_credits = DEPTH;
    int    hold_err   = 0;
    bit    pend       = 1'b0;
    beat_t held;

    flit_rx_reassembler #(
        .TDATA_WIDTH          (TW),
        .DEST_WIDTH           (DW),
        .SERIALIZATION_FACTOR (SF),
        .FLIT_BUFFER_DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .dest_in     (dest_in),
        .is_tail_in  (is_tail_in),
        .send_in     (send_in),
        .credit_out  (credit_out),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .axis_tdata  (axis_tdata),
        .axis_tlast  (axis_tlast),
        .axis_tdest  (axis_tdest),
        .overflow    (overflow)
`ifdef FLIT_RX_STATS_EN
        ,
        .beat_count  (beat_count),
        .pkt_count   (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    // Observe mid-cycle: collect beats, count credits, and flag any beat
    // that changes or drops valid before it is accepted.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (credit_out === 1'b1) begin
                credit_cnt++;
                tb_credits++;
            end
            if (pend && (axis_tvalid !== 1'b1 ||
                         axis_tdata !== held.data ||
                         axis_tdest !== held.dest ||
                         axis_tlast !== held.last)) begin
                hold_err++;
            end
            held.data = axis_tdata;
            held.dest = axis_tdest;
            held.last = axis_tlast;
            pend = (axis_tvalid === 1'b1) && (axis_tready === 1'b0);
            if (axis_tvalid === 1'b1 && axis_tready === 1'b1) begin
                obs.push_back(held);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst         = 1'b1;
        send_in     = 1'b0;
        axis_tready = 1'b0;
        repeat (n) tick();
        rst        = 1'b0;
        obs.delete();
        credit_cnt = 0;
        tb_credits = DEPTH;
        hold_err   = 0;
    endtask

    // Reference model: a packet of n flits becomes ceil(n/SF) beats; each
    // beat takes the dest of its first flit, unused slots are zero and
    // only the final beat carries tlast.
    task automatic add_packet(input int n, input logic [31:0] base,
                              input logic [DW-1:0] dest, input bit rnd);
        flit_t f[$];
        for (int i = 0; i < n; i++) begin
            flit_t x;
            x.data = rnd ? {$urandom, $urandom, $urandom, $urandom}
                         : {4{base + 32'(i)}};
            x.dest = rnd ? DW'($urandom) : dest;
            x.tail = (i == n - 1);
            f.push_back(x);
            tx_q.push_back(x);
        end
        for (int b = 0; b * SF < n; b++) begin
            beat_t e;
            e.data = '0;
            for (int k = 0; k < SF && b * SF + k < n; k++) begin
                e.data[k*FW +: FW] = f[b*SF+k].data;
            end
            e.dest = f[b*SF].dest;
            e.last = ((b + 1) * SF >= n);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_one(input flit_t f);
        data_in    = f.data;
        dest_in    = f.dest;
        is_tail_in = f.tail;
        send_in    = 1'b1;
        tick();
        send_in    = 1'b0;
    endtask

    // Credit-respecting driver; stops when everything expected has been
    // delivered or the cycle budget runs out.
    task automatic drive(input int budget, input bit always_ready,
                         input int gap_pct);
        int cyc = 0;
        while ((tx_q.size() != 0 || obs.size() < exp_q.size()) &&
               cyc < budget) begin
            axis_tready = always_ready ? 1'b1
                                       : ($urandom_range(0, 99) < 70);
            if (tx_q.size() != 0 && tb_credits > 0 &&
                $urandom_range(0, 99) >= gap_pct) begin
                flit_t f;
                f = tx_q.pop_front();
                data_in    = f.data;
                dest_in    = f.dest;
                is_tail_in = f.tail;
                send_in    = 1'b1;
                tb_credits--;
            end else begin
                send_in = 1'b0;
            end
            tick();
            cyc++;
        end
        send_in     = 1'b0;
        axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(2);
        total++;
        if (axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_tvalid: got %b want 0", axis_tvalid);
        end
        total++;
        if (credit_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_credit: got %b want 0", credit_out);
        end
        total++;
        if (axis_tlast !== 1'b0) begin
            bad++;
            $display("FAIL reset_tlast: got %b want 0", axis_tlast);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_overflow: got %b want 0", overflow);
        end
        total++;
        if (axis_tdata !== {TW{1'b0}}) begin
            bad++;
            $display("FAIL reset_tdata: got %h want 0", axis_tdata);
        end
        total++;
        if (axis_tdest !== {DW{1'b0}}) begin
            bad++;
            $display("FAIL reset_tdest: got %h want 0", axis_tdest);
        end
    endtask

    task automatic test_full_packet();
        flit_t x;
        do_reset(1);
        tx_q.delete();
        exp_q.delete();
        axis_tready = 1'b1;
        add_packet(4, 32'h0000_00A0, 6'h15, 1'b0);
        x = tx_q.pop_front();
        send_one(x);
        total++;
        if (credit_out !== 1'b0) begin
            bad++;
            $display("FAIL full_credit_t1: got %b want 0", credit_out);
        end
        x = tx_q.pop_front();
        send_one(x);
        total++;
        if (credit_out !== 1'b1) begin
            bad++;
            $display("FAIL full_credit_t2: got %b want 1", credit_out);
        end
        repeat (2) begin
            x = tx_q.pop_front();
            send_one(x);
        end
        tick();
        total++;
        if (axis_tvalid !== 1'b1 || axis_tdata !== exp_q[0].data ||
            axis_tdest !== 6'h15 || axis_tlast !== 1'b1) begin
            bad++;
            $display("FAIL full_beat_latency: got v=%b d=%h dest=%h l=%b want v=1 d=%h dest=15 l=1",
                     axis_tvalid, axis_tdata, axis_tdest, axis_tlast,
                     exp_q[0].data);
        end
        repeat (4) tick();
        total++;
        if (obs.size() != 1) begin
            bad++;
            $display("FAIL full_beat_count: got %0d want 1", obs.size());
        end
        total++;
        if (credit_cnt != 4) begin
            bad++;
            $display("FAIL full_credits: got %0d want 4", credit_cnt);
        end
    endtask

    task automatic test_short_packet();
        tx_q.delete();
        exp_q.delete();
        obs.delete();
        credit_cnt  = 0;
        tb_credits  = DEPTH;
        axis_tready = 1'b1;
        add_packet(2, 32'h0000_00B0, 6'h0B, 1'b0);
        add_packet(4, 32'h0000_00E0, 6'h21, 1'b0);
        drive(200, 1'b1, 0);
        repeat (4) tick();
        total++;
        if (obs.size() != 2) begin
            bad++;
            $display("FAIL short_beat_count: got %0d want 2", obs.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs.size() || obs[i].data !== exp_q[i].data ||
                obs[i].dest !== exp_q[i].dest ||
                obs[i].last !== exp_q[i].last) begin
                bad++;
                $display("FAIL short_beat%0d: got %h/%h/%b want %h/%h/%b",
                         i, (i < obs.size()) ? obs[i].data : '0,
                         (i < obs.size()) ? obs[i].dest : '0,
                         (i < obs.size()) ? obs[i].last : 1'b0,
                         exp_q[i].data, exp_q[i].dest, exp_q[i].last);
            end
        end
        total++;
        if (credit_cnt != 6) begin
            bad++;
            $display("FAIL short_credits: got %0d want 6", credit_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset(1);
        tx_q.delete();
        exp_q.delete();
        add_packet(8, 32'h0000_00C0, 6'h2A, 1'b0);
        axis_tready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (tx_q.size() != 0 && tb_credits > 0) begin
                flit_t f;
                f = tx_q.pop_front();
                data_in    = f.data;
                dest_in    = f.dest;
                is_tail_in = f.tail;
                send_in    = 1'b1;
                tb_credits--;
            end else begin
                send_in = 1'b0;
            end
            tick();
            if (c >= 8) begin
                total++;
                if (axis_tvalid !== 1'b1 ||
                    axis_tdata !== exp_q[0].data) begin
                    bad++;
                    $display("FAIL bp_hold_c%0d: got v=%b d=%h want v=1 d=%h",
                             c, axis_tvalid, axis_tdata, exp_q[0].data);
                end
            end
        end
        send_in = 1'b0;
        total++;
        if (credit_cnt != 4) begin
            bad++;
            $display("FAIL bp_credits_stalled: got %0d want 4", credit_cnt);
        end
        total++;
        if (tx_q.size() != 0) begin
            bad++;
            $display("FAIL bp_all_sent: got %0d unsent want 0", tx_q.size());
        end
        drive(100, 1'b1, 0);
        repeat (4) tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs.size() || obs[i].data !== exp_q[i].data ||
                obs[i].dest !== exp_q[i].dest ||
                obs[i].last !== exp_q[i].last) begin
                bad++;
                $display("FAIL bp_beat%0d: got %0d beats, want %h/%h/%b",
                         i, obs.size(), exp_q[i].data, exp_q[i].dest,
                         exp_q[i].last);
            end
        end
        total++;
        if (credit_cnt != 8 || hold_err != 0) begin
            bad++;
            $display("FAIL bp_final: got credits=%0d hold_err=%0d want 8/0",
                     credit_cnt, hold_err);
        end
    endtask

    task automatic test_overflow();
        flit_t x;
        int    c;
        // Part 1: assembly holds a beat, then 5 back-to-back flits.
        do_reset(1);
        tx_q.delete();
        exp_q.delete();
        add_packet(8, 32'h0000_00D0, 6'h33, 1'b0);
        repeat (4) begin
            x = tx_q.pop_front();
            send_one(x);
        end
        c = 0;
        while (axis_tvalid !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        total++;
        if (axis_tvalid !== 1'b1) begin
            bad++;
            $display("FAIL ovf_wait_valid: got %b want 1", axis_tvalid);
        end
        repeat (4) begin
            x = tx_q.pop_front();
            send_one(x);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_at_full: got %b want 0", overflow);
        end
        x.data = {4{32'hDEAD_BEEF}};
        x.dest = 6'h3F;
        x.tail = 1'b1;
        send_one(x);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_fifth: got %b want 1", overflow);
        end
        repeat (5) tick();
        axis_tready = 1'b1;
        repeat (20) tick();
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        total++;
        if (obs.size() != 2) begin
            bad++;
            $display("FAIL ovf_beats: got %0d want 2", obs.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs.size() || obs[i].data !== exp_q[i].data ||
                obs[i].last !== exp_q[i].last) begin
                bad++;
                $display("FAIL ovf_beat%0d: got %0d beats, want %h/%b",
                         i, obs.size(), exp_q[i].data, exp_q[i].last);
            end
        end
        // Part 2: full FIFO, dequeue and send in the same cycle.
        do_reset(1);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_cleared: got %b want 0", overflow);
        end
        tx_q.delete();
        exp_q.delete();
        add_packet(8, 32'h0000_0070, 6'h12, 1'b0);
        repeat (4) begin
            x = tx_q.pop_front();
            send_one(x);
        end
        c = 0;
        while (axis_tvalid !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        repeat (4) begin
            x = tx_q.pop_front();
            send_one(x);
        end
        axis_tready = 1'b1;
        x.data = {4{32'hFEED_0001}};
        x.dest = 6'h01;
        x.tail = 1'b1;
        send_one(x);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_same_cycle_deq: got %b want 1", overflow);
        end
        repeat (20) tick();
        total++;
        if (obs.size() != 2 || obs[1].data !== exp_q[1].data) begin
            bad++;
            $display("FAIL ovf2_beats: got %0d beats want 2 ending %h",
                     obs.size(), exp_q[1].data);
        end
    endtask

    task automatic test_reset_mid_packet();
        flit_t x;
        do_reset(1);
        tx_q.delete();
        exp_q.delete();
        axis_tready = 1'b1;
        add_packet(4, 32'h0000_0050, 6'h05, 1'b0);
        repeat (2) begin
            x = tx_q.pop_front();
            send_one(x);
        end
        tick();
        do_reset(1);
        tx_q.delete();
        exp_q.delete();
        axis_tready = 1'b1;
        total++;
        if (axis_tvalid !== 1'b0 || credit_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outs: got v=%b c=%b want 0/0",
                     axis_tvalid, credit_out);
        end
        repeat (6) tick();
        total++;
        if (credit_cnt != 0 || obs.size() != 0) begin
            bad++;
            $display("FAIL mid_reset_idle: got credits=%0d beats=%0d want 0/0",
                     credit_cnt, obs.size());
        end
        add_packet(4, 32'h0000_00F0, 6'h07, 1'b0);
        drive(100, 1'b1, 0);
        repeat (4) tick();
        total++;
        if (obs.size() != 1 || obs[0].data !== exp_q[0].data ||
            obs[0].dest !== 6'h07 || obs[0].last !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_fresh: got %0d beats want 1 of %h",
                     obs.size(), exp_q[0].data);
        end
        total++;
        if (credit_cnt != 4) begin
            bad++;
            $display("FAIL mid_reset_credits: got %0d want 4", credit_cnt);
        end
    endtask

    task automatic test_random();
        int nflits = 0;
        do_reset(1);
        tx_q.delete();
        exp_q.delete();
        for (int p = 0; p < 30; p++) begin
            int n;
            n = $urandom_range(1, 10);
            nflits += n;
            add_packet(n, 32'h0, 6'h0, 1'b1);
        end
        drive(20000, 1'b0, 30);
        repeat (10) tick();
        total++;
        if (obs.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_beat_count: got %0d want %0d",
                     obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs.size() || obs[i].data !== exp_q[i].data ||
                obs[i].dest !== exp_q[i].dest ||
                obs[i].last !== exp_q[i].last) begin
                bad++;
                $display("FAIL rand_beat%0d: got %h/%h/%b want %h/%h/%b",
                         i, (i < obs.size()) ? obs[i].data : '0,
                         (i < obs.size()) ? obs[i].dest : '0,
                         (i < obs.size()) ? obs[i].last : 1'b0,
                         exp_q[i].data, exp_q[i].dest, exp_q[i].last);
            end
        end
        total++;
        if (credit_cnt != nflits || tb_credits != DEPTH) begin
            bad++;
            $display("FAIL rand_credits: got %0d (pool %0d) want %0d (pool %0d)",
                     credit_cnt, tb_credits, nflits, DEPTH);
        end
        total++;
        if (hold_err != 0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL rand_protocol: got hold_err=%0d ovf=%b want 0/0",
                     hold_err, overflow);
        end
    endtask

`ifdef FLIT_RX_STATS_EN
    task automatic test_stats();
        do_reset(1);
        tx_q.delete();
        exp_q.delete();
        total++;
        if (beat_count !== 32'd0 || pkt_count !== 32'd0) begin
            bad++;
            $display("FAIL stats_reset: got %0d/%0d want 0/0",
                     beat_count, pkt_count);
        end
        add_packet(8, 32'h0000_1000, 6'h01, 1'b0);
        add_packet(4, 32'h0000_2000, 6'h02, 1'b0);
        add_packet(12, 32'h0000_3000, 6'h03, 1'b0);
        drive(2000, 1'b0, 20);
        repeat (5) tick();
        total++;
        if (beat_count !== 32'd6 || pkt_count !== 32'd3) begin
            bad++;
            $display("FAIL stats_counts: got %0d/%0d want 6/3",
                     beat_count, pkt_count);
        end
    endtask
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        send_in     = 1'b0;
        data_in     = '0;
        dest_in     = '0;
        is_tail_in  = 1'b0;
        axis_tready = 1'b0;
        test_reset();
        test_full_packet();
        test_short_packet();
        test_backpressure();
        test_overflow();
        test_reset_mid_packet();
        test_random();
`ifdef FLIT_RX_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
